// File: rtl/frame_draw_ctrl_if.sv
// Pixel write bus from the draw sequencer (master) to the VGA adapter (slave).
interface frame_draw_ctrl_if;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;

  modport master (output x_out, y_out, colour_out, plot);
  modport slave  (input  x_out, y_out, colour_out, plot);
endinterface

// File: rtl/frame_draw_ctrl.sv
// Per-frame draw sequencer: one full erase sweep, then ball and both paddles rasterised as
// filled rectangles, one registered pixel per clock towards the VGA adapter.
module frame_draw_ctrl #(
  parameter int unsigned SCR_W        = 160,
  parameter int unsigned SCR_H        = 120,
  parameter int unsigned ERASE_CYCLES = 65531,
  parameter int unsigned BALL_SZ      = 4,
  parameter int unsigned PAD_W        = 4,
  parameter int unsigned PAD_H        = 16,
  parameter int unsigned LPAD_X       = 4,
  parameter int unsigned RPAD_X       = 152,
  parameter logic [2:0]  BALL_COL     = 3'b111,
  parameter logic [2:0]  PAD_COL      = 3'b111
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              frame_tick,
  input  logic [7:0]        ex_in,
  input  logic [6:0]        ey_in,
  input  logic [2:0]        ecol_in,
  input  logic [7:0]        ball_x,
  input  logic [6:0]        ball_y,
  input  logic [6:0]        lpad_y,
  input  logic [6:0]        rpad_y,
  output logic              erase_en,
  output logic              busy,
  output logic              frame_done,
  frame_draw_ctrl_if.master pix
);
  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_BALL, S_LPAD, S_RPAD, S_DONE} state_t;

  typedef struct packed {
    logic [7:0] bx;
    logic [6:0] by;
    logic [6:0] ly;
    logic [6:0] ry;
  } snap_t;

  localparam logic [15:0] ERASE_LAST = 16'(ERASE_CYCLES - 1);
  localparam logic [8:0]  SCR_W9     = 9'(SCR_W);
  localparam logic [7:0]  SCR_H8     = 8'(SCR_H);

  state_t      state, next_sprite;
  snap_t       snap;
  logic [15:0] cnt;
  logic [7:0]  dx;
  logic [6:0]  dy;

  logic [8:0]  sp_x, px;
  logic [7:0]  sp_y, py;
  logic [7:0]  sp_w;
  logic [6:0]  sp_h;
  logic [2:0]  sp_col;
  logic        dx_last, dy_last, e_vis, s_vis;

  assign erase_en = (state == S_ERASE);

  // Geometry of the rectangle being rasterised; the ball is the fallback outside LPAD/RPAD.
  always_comb begin
    sp_x        = {1'b0, snap.bx};
    sp_y        = {1'b0, snap.by};
    sp_w        = 8'(BALL_SZ);
    sp_h        = 7'(BALL_SZ);
    sp_col      = BALL_COL;
    next_sprite = S_LPAD;
    case (state)
      S_LPAD: begin
        sp_x        = 9'(LPAD_X);
        sp_y        = {1'b0, snap.ly};
        sp_w        = 8'(PAD_W);
        sp_h        = 7'(PAD_H);
        sp_col      = PAD_COL;
        next_sprite = S_RPAD;
      end
      S_RPAD: begin
        sp_x        = 9'(RPAD_X);
        sp_y        = {1'b0, snap.ry};
        sp_w        = 8'(PAD_W);
        sp_h        = 7'(PAD_H);
        sp_col      = PAD_COL;
        next_sprite = S_DONE;
      end
      default: ;
    endcase
  end

  // Widened sums keep off-screen pixels from wrapping back onto the visible area.
  assign px      = sp_x + {1'b0, dx};
  assign py      = sp_y + {1'b0, dy};
  assign dx_last = (dx == sp_w - 8'd1);
  assign dy_last = (dy == sp_h - 7'd1);
  assign s_vis   = (px < SCR_W9) && (py < SCR_H8);
  assign e_vis   = ({1'b0, ex_in} < SCR_W9) && ({1'b0, ey_in} < SCR_H8);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      snap           <= '0;
      cnt            <= '0;
      dx             <= '0;
      dy             <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      pix.x_out      <= '0;
      pix.y_out      <= '0;
      pix.colour_out <= '0;
      pix.plot       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          pix.plot <= 1'b0;
          if (frame_tick) begin
            snap  <= '{bx: ball_x, by: ball_y, ly: lpad_y, ry: rpad_y};
            cnt   <= '0;
            dx    <= '0;
            dy    <= '0;
            busy  <= 1'b1;
            state <= S_ERASE;
          end
        end
        // erase_all free-runs, so a full period of its counter covers every pixel.
        S_ERASE: begin
          pix.x_out      <= ex_in;
          pix.y_out      <= ey_in;
          pix.colour_out <= ecol_in;
          pix.plot       <= e_vis;
          if (cnt == ERASE_LAST) begin
            cnt   <= '0;
            state <= S_BALL;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_BALL, S_LPAD, S_RPAD: begin
          pix.x_out      <= px[7:0];
          pix.y_out      <= py[6:0];
          pix.colour_out <= sp_col;
          pix.plot       <= s_vis;
          if (dx_last) begin
            dx <= '0;
            if (dy_last) begin
              dy    <= '0;
              state <= next_sprite;
              if (state == S_RPAD) frame_done <= 1'b1;
            end else begin
              dy <= dy + 7'd1;
            end
          end else begin
            dx <= dx + 8'd1;
          end
        end
        S_DONE: begin
          pix.plot <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_draw_ctrl.sv
// Directed/random frame bench: a short-erase instance exercises most frames, a default
// instance checks one full-length frame; every output cycle is compared to a pixel list.
module tb_frame_draw_ctrl;
  localparam int SE = 24;
  localparam int FE = 65531;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s, rst_f, tick_s, tick_f, sel;
  logic [7:0] ex_in, ball_x;
  logic [6:0] ey_in, ball_y, lpad_y, rpad_y;
  logic [2:0] ecol_in;
  logic       erase_en_s, busy_s, done_s, erase_en_f, busy_f, done_f;

  frame_draw_ctrl_if pix_s();
  frame_draw_ctrl_if pix_f();

  frame_draw_ctrl #(.ERASE_CYCLES(SE)) u_small (
    .clk(clk), .resetn(rst_s), .frame_tick(tick_s),
    .ex_in(ex_in), .ey_in(ey_in), .ecol_in(ecol_in),
    .ball_x(ball_x), .ball_y(ball_y), .lpad_y(lpad_y), .rpad_y(rpad_y),
    .erase_en(erase_en_s), .busy(busy_s), .frame_done(done_s), .pix(pix_s));

  frame_draw_ctrl u_full (
    .clk(clk), .resetn(rst_f), .frame_tick(tick_f),
    .ex_in(ex_in), .ey_in(ey_in), .ecol_in(ecol_in),
    .ball_x(ball_x), .ball_y(ball_y), .lpad_y(lpad_y), .rpad_y(rpad_y),
    .erase_en(erase_en_f), .busy(busy_f), .frame_done(done_f), .pix(pix_f));

  logic [3:0]  o_ctl;
  logic [17:0] o_pix;
  always_comb begin
    o_ctl = sel ? {busy_f, erase_en_f, done_f, pix_f.plot}
                : {busy_s, erase_en_s, done_s, pix_s.plot};
    o_pix = sel ? {pix_f.x_out, pix_f.y_out, pix_f.colour_out}
                : {pix_s.x_out, pix_s.y_out, pix_s.colour_out};
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Expected pixel list entries: {plot, x, y, colour}.
  logic [18:0] eq[$];
  logic [18:0] sq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_rect(input int bx, input int by, input int w, input int h,
                          input logic [2:0] col);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        int xx;
        int yy;
        xx = bx + c;
        yy = by + r;
        sq.push_back({(xx < 160 && yy < 120), 8'(xx), 7'(yy), col});
      end
  endtask

  task automatic drive_erase();
    case ($urandom_range(0, 3))
      0:       ex_in = 8'd159;
      1:       ex_in = 8'd160;
      default: ex_in = 8'($urandom_range(0, 255));
    endcase
    case ($urandom_range(0, 3))
      0:       ey_in = 7'd119;
      1:       ey_in = 7'd120;
      default: ey_in = 7'($urandom_range(0, 127));
    endcase
    ecol_in = 3'($urandom_range(0, 7));
  endtask

  task automatic rand_sprites();
    ball_x = 8'($urandom_range(0, 170));
    ball_y = 7'($urandom_range(0, 127));
    lpad_y = 7'($urandom_range(0, 127));
    rpad_y = 7'($urandom_range(0, 127));
  endtask

  task automatic set_tick(input bit big, input logic v);
    if (big) tick_f = v;
    else     tick_s = v;
  endtask

  // Called just after a negedge; leaves the bench just after a negedge.
  task automatic run_frame(input bit big, input bit mid_tick, input bit mid_chg,
                           input bit done_tick);
    int          ne;
    int          total;
    logic [18:0] ent;
    logic [3:0]  e_ctl;
    ne    = big ? FE : SE;
    total = ne + 145;
    sel   = big;
    eq.delete();
    sq.delete();
    add_rect(int'(ball_x), int'(ball_y), 4, 4, 3'b111);
    add_rect(4, int'(lpad_y), 4, 16, 3'b111);
    add_rect(152, int'(rpad_y), 4, 16, 3'b111);
    set_tick(big, 1'b1);
    drive_erase();
    @(negedge clk);
    for (int i = 1; i <= total + 2; i++) begin
      ent = 19'd0;
      if (i >= 2 && i <= total) ent = (i - 2 < ne) ? eq[i-2] : sq[i-2-ne];
      e_ctl = {(i <= total), (i <= ne), (i == total), ent[18]};
      check(big ? "ctl_full" : "ctl", 32'(o_ctl), 32'(e_ctl));
      if (i >= 2 && i <= total) check(big ? "pix_full" : "pix", 32'(o_pix), 32'(ent[17:0]));
      set_tick(big, (mid_tick && i == 100) || (done_tick && i == total));
      if (mid_chg && i == 50) rand_sprites();
      drive_erase();
      if (i <= ne) eq.push_back({(int'(ex_in) < 160 && int'(ey_in) < 120), ex_in, ey_in, ecol_in});
      @(negedge clk);
    end
    set_tick(big, 1'b0);
  endtask

  initial begin
    rst_s = 1'b0; rst_f = 1'b0; tick_s = 1'b0; tick_f = 1'b0; sel = 1'b0;
    ex_in = '0; ey_in = '0; ecol_in = '0;
    ball_x = '0; ball_y = '0; lpad_y = '0; rpad_y = '0;
    repeat (2) @(negedge clk);
    check("rst_ctl_s", 32'(o_ctl), 32'd0);
    check("rst_pix_s", 32'(o_pix), 32'd0);
    sel = 1'b1;
    #1;
    check("rst_ctl_f", 32'(o_ctl), 32'd0);
    check("rst_pix_f", 32'(o_pix), 32'd0);
    rst_s = 1'b1; rst_f = 1'b1;
    @(negedge clk);

    // Ball at (10,20), DONE-cycle tick must be dropped.
    ball_x = 8'd10; ball_y = 7'd20; lpad_y = 7'd50; rpad_y = 7'd60;
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of erase, tick held during reset.
    sel = 1'b0;
    tick_s = 1'b1;
    @(negedge clk);
    tick_s = 1'b0;
    repeat (10) @(negedge clk);
    check("erase_en_mid", 32'(erase_en_s), 32'd1);
    rst_s = 1'b0;
    tick_s = 1'b1;
    #1;
    check("async_rst_ctl", 32'(o_ctl), 32'd0);
    check("async_rst_pix", 32'(o_pix), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("in_rst_busy", 32'(busy_s), 32'd0);
    end
    tick_s = 1'b0;
    rst_s  = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(o_ctl), 32'd0);
    rand_sprites();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Right paddle hanging off the bottom edge.
    rand_sprites();
    rpad_y = 7'd110;
    run_frame(1'b0, 1'b1, 1'b0, 1'b0);

    // Mid-frame input change; the following frame picks up the new values.
    rand_sprites();
    run_frame(1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 3; f++) begin
      rand_sprites();
      run_frame(1'b0, 1'b1, 1'b1, 1'b1);
    end

    // Full-length frame with a dropped tick 100 cycles in and a mid-frame ball change.
    ball_x = 8'd157; ball_y = 7'd117; lpad_y = 7'd0; rpad_y = 7'd104;
    run_frame(1'b1, 1'b1, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
